// File: rtl/clk_rate_mon_pkg.sv
// Shared defaults and per-channel result type for the multi-channel clock rate monitor.
package clk_rate_mon_pkg;

  localparam int unsigned DEF_NUM_CH        = 4;
  localparam int unsigned DEF_COUNTER_WIDTH = 32;
  localparam int unsigned DEF_WINDOW_CYCLES = 100000;
  localparam int unsigned DEF_SYNC_STAGES   = 2;

  // Widest per-channel count carried in the result struct; narrower counts are zero-extended.
  localparam int unsigned RESULT_W = 64;

  typedef struct packed {
    logic [RESULT_W-1:0] count;
    logic                in_range;
  } chan_result_t;

endpackage

// File: rtl/clk_rate_mon_chan.sv
// One monitored channel: synchronizer, any-edge detect, saturating window count, range compare.
// Threshold compare and sticky alarm exist only when CLK_RATE_MON_ALARM_EN is defined.
module clk_rate_mon_chan
  import clk_rate_mon_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                     clk_ref,
  input  logic                     reset_in_n,
  input  logic                     enable,
  input  logic                     win_last,
  input  logic                     toggle,
  input  logic [COUNTER_WIDTH-1:0] lo,
  input  logic [COUNTER_WIDTH-1:0] hi,
  input  logic                     clear,
  output chan_result_t             result,
  output logic                     alarm
);

  logic [SYNC_STAGES-1:0]   sync;
  logic                     prev;
  logic                     hit;
  logic [COUNTER_WIDTH-1:0] count;
  logic [COUNTER_WIDTH-1:0] count_next;
  logic [COUNTER_WIDTH-1:0] value_q;
  logic                     in_range_q;
  logic                     new_in_range;

  always_ff @(posedge clk_ref or negedge reset_in_n) begin
    if (!reset_in_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], toggle};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign hit = sync[SYNC_STAGES-1] ^ prev;

  always_comb begin
    count_next = count;
    if (!(&count)) count_next = count + COUNTER_WIDTH'(hit);
  end

`ifdef CLK_RATE_MON_ALARM_EN
  assign new_in_range = (count_next >= lo) && (count_next <= hi);
`else
  assign new_in_range = 1'b1;
`endif

  // The closing count already includes this cycle's edge, so clearing here loses nothing.
  always_ff @(posedge clk_ref or negedge reset_in_n) begin
    if (!reset_in_n) begin
      count      <= '0;
      value_q    <= '1;
      in_range_q <= 1'b0;
    end else begin
      if (!enable || win_last) count <= '0;
      else                     count <= count_next;
      if (win_last) begin
        value_q    <= count_next;
        in_range_q <= new_in_range;
      end
    end
  end

`ifdef CLK_RATE_MON_ALARM_EN
  always_ff @(posedge clk_ref or negedge reset_in_n) begin
    if (!reset_in_n) alarm <= 1'b0;
    else if (enable) alarm <= (alarm & ~clear) | (win_last & ~new_in_range);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{lo, hi, clear};
  assign alarm      = 1'b0;
`endif

  assign result = '{count: RESULT_W'(value_q), in_range: in_range_q};

endmodule

// File: rtl/clk_rate_mon_multi.sv
// Multi-channel clock rate monitor: shared measurement window, per-channel counters and results.
// Define CLK_RATE_MON_ALARM_EN to enable threshold compare and sticky alarms.
module clk_rate_mon_multi
  import clk_rate_mon_pkg::*;
#(
  parameter int unsigned NUM_CH        = DEF_NUM_CH,
  parameter int unsigned COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                            clk_ref,
  input  logic                            reset_in_n,
  input  logic                            enable,
  input  logic [NUM_CH-1:0]               toggle_in,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] lo_thresh,
  input  logic [NUM_CH*COUNTER_WIDTH-1:0] hi_thresh,
  input  logic                            alarm_clear,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] value,
  output logic                            value_valid,
  output logic [NUM_CH-1:0]               in_range,
  output logic [NUM_CH-1:0]               alarm_sticky
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  logic [WIN_W-1:0] win_cnt;
  logic             win_last;

  assign win_last = enable && (win_cnt == WIN_W'(WINDOW_CYCLES - 1));

  always_ff @(posedge clk_ref or negedge reset_in_n) begin
    if (!reset_in_n) begin
      win_cnt     <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= win_last;
      if (!enable || win_last) win_cnt <= '0;
      else                     win_cnt <= win_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    chan_result_t res;

    clk_rate_mon_chan #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_chan (
      .clk_ref   (clk_ref),
      .reset_in_n(reset_in_n),
      .enable    (enable),
      .win_last  (win_last),
      .toggle    (toggle_in[i]),
      .lo        (lo_thresh[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .hi        (hi_thresh[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
      .clear     (alarm_clear),
      .result    (res),
      .alarm     (alarm_sticky[i])
    );

    assign value[i*COUNTER_WIDTH +: COUNTER_WIDTH] = res.count[COUNTER_WIDTH-1:0];
    assign in_range[i]                             = res.in_range;

    if (COUNTER_WIDTH < RESULT_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^res.count[RESULT_W-1:COUNTER_WIDTH];
    end
  end

endmodule

// File: doc/clk_rate_mon_multi.md
CLK_RATE_MON_MULTI -- requirements
Module: clk_rate_mon_multi

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- NUM_CH, 4, monitored channels.
- COUNTER_WIDTH, 32, per-channel count width.
- WINDOW_CYCLES, 100000, measurement window length in clk_ref cycles.
- SYNC_STAGES, 2, synchronizer depth (2..4).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk_ref, in, 1, sole clock.
- reset_in_n, in, 1, asynchronous active-low reset.
- enable, in, 1, run measurement.
- toggle_in, in, NUM_CH, per-channel toggle (test clock divided by 2 in its own domain), asynchronous.
- lo_thresh, in, NUM_CH*COUNTER_WIDTH, per-channel minimum acceptable count.
- hi_thresh, in, NUM_CH*COUNTER_WIDTH, per-channel maximum acceptable count.
- alarm_clear, in, 1, clear sticky alarms.
- value, out, NUM_CH*COUNTER_WIDTH, last window count per channel.
- value_valid, out, 1, one-cycle new-result strobe.
- in_range, out, NUM_CH, last result within thresholds.
- alarm_sticky, out, NUM_CH, latched out-of-range flag.
REQ-003 The block SHALL have one clock, clk_ref; reset_in_n SHALL be asynchronous and active-low.

Function
REQ-004 Each toggle_in bit SHALL pass through SYNC_STAGES flops, then an any-edge detector; each detected edge counts one test-clock cycle.
REQ-005 Edge-to-count latency SHALL be SYNC_STAGES+1 clk_ref cycles.
REQ-006 Correct counting SHALL require each toggle_in level to be stable at least 2 clk_ref cycles; faster inputs undercount, with no other required behaviour.
REQ-007 The window counter SHALL run 0..WINDOW_CYCLES-1 while enable=1, then wrap to 0.
REQ-008 At window counter WINDOW_CYCLES-1, each channel SHALL load value with its count plus any edge detected that cycle.
REQ-009 On the same cycle as REQ-008, the count SHALL reset to 0, so no edge is lost or double-counted across the boundary.
REQ-010 value_valid SHALL be high exactly in the first cycle the new value is visible, for one cycle per window.
REQ-011 Channel counts SHALL saturate at all-ones and not wrap.
REQ-012 in_range[i] SHALL update with value and equal (lo_thresh[i] <= new value[i] <= hi_thresh[i]), unsigned.
REQ-013 lo_thresh > hi_thresh SHALL give in_range=0.
REQ-014 alarm_sticky[i] SHALL set on any value_valid cycle where in_range[i] is 0.
REQ-015 alarm_sticky SHALL clear on alarm_clear; if set and clear coincide, set wins.
REQ-016 enable=0 SHALL hold the window counter and channel counts at 0 and freeze value, in_range and alarm_sticky; value_valid SHALL stay 0.
REQ-017 On enable 0->1, a full fresh window of WINDOW_CYCLES cycles SHALL precede the next value_valid.
REQ-018 Dropping enable mid-window SHALL discard the partial window.

Reset
REQ-019 Reset SHALL set:
- value to all-ones (no measurement yet);
- value_valid, in_range, alarm_sticky, all counters and synchronizer flops to 0.
REQ-020 Reset assertion mid-window SHALL abort the window with no value_valid.
REQ-021 Deassertion SHALL start a fresh window if enable=1.

Configuration
REQ-022 Macro CLK_RATE_MON_ALARM_EN defined: threshold compare and sticky alarms SHALL be present per REQ-012..015.
REQ-023 Macro undefined: in_range SHALL be all-ones after the first value_valid (0 before), alarm_sticky SHALL be constant 0, and lo_thresh, hi_thresh and alarm_clear SHALL be ignored.

Structure
REQ-024 Package clk_rate_mon_pkg SHALL hold the default-parameter constants and the per-channel result struct (count, in_range).
REQ-025 Per-channel synchronizer, edge detect, saturating counter and compare SHALL be sub-module clk_rate_mon_chan, instantiated NUM_CH times.
REQ-026 Window timing and value_valid SHALL live in the top level.

Verification (WINDOW_CYCLES=1000, NUM_CH=4, COUNTER_WIDTH=16, SYNC_STAGES=2)
REQ-027 Toggles at ref/4, ref/8, ref/10 and constant on ch0..3 -> value = 250, 125, 100, 0 at each value_valid, one pulse per 1000 cycles.
REQ-028 ch0 at ref/4 with thresholds 240..260, then ch0 toggling every 3 cycles (333 edges) -> in_range[0] 1 then 0, alarm_sticky[0] set and held.
REQ-029 Set and clear together -> alarm_sticky stays 1; next clear alone -> 0.
REQ-030 Toggle edge placed exactly at window boundary over 10 windows -> sum of values equals total edges driven.
REQ-031 enable dropped at cycle 500 for 200 cycles -> no value_valid for that window, next value_valid 1000 cycles after re-enable.
REQ-032 COUNTER_WIDTH=8 with 250 edges per window -> value = 250; 300 edges -> value = 255 (saturation).
REQ-033 reset_in_n pulsed mid-window -> value = 0xFFFF, all flags 0, value_valid absent until a fresh window completes.
